apb4_arbiter: RTL and testbench

- Shares one downstream APB4 master port among NUM_REQ upstream APB4 requesters (e.g. core LSU, debug module, DMA).
- Sits between the requesters and the peripheral address-decode mux.
- Arbitrates round-robin and generates its own APB SETUP/ACCESS sequencing downstream.
- Returns PREADY/PRDATA/PSLVERR only to the granted requester.

---
 rtl/apb4_arbiter_pkg.sv | 10 +
 rtl/apb4_arbiter_if.sv | 22 ++
 rtl/apb4_arbiter_rr.sv | 29 ++
 rtl/apb4_arbiter.sv | 114 +++++++++++
 tb/tb_apb4_arbiter.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/apb4_arbiter_pkg.sv
// apb4_arb_pkg: FSM state type and width helpers shared by the APB4 arbiter files
package apb4_arb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} arb_state_e;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int strb_w(input int dw);
    return dw / 8;
  endfunction
endpackage

// File: rtl/apb4_arbiter_if.sv
// apb4_intf: APB4 bus bundle; master modport drives the request, slave modport drives the response
interface apb4_intf #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  import apb4_arb_pkg::*;
  localparam int STRB_WIDTH = strb_w(DATA_WIDTH);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [STRB_WIDTH-1:0] PSTRB;
  logic [2:0]            PPROT;
  logic                  PREADY;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PSLVERR;
  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
                  input PREADY, PRDATA, PSLVERR);
  modport slave (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
                 output PREADY, PRDATA, PSLVERR);
endinterface

// File: rtl/apb4_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick starting at ptr_i, skipping requests in excl_i
// Ports: req_i/excl_i request and exclude masks, ptr_i search start; gnt_o one-hot, idx_o encoded, valid_o any winner.
module rr_arbiter import apb4_arb_pkg::*; #(
  parameter int N = 2,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic [N-1:0]  excl_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);
  logic [IW-1:0] j;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    valid_o = 1'b0;
    j = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(ptr_i) + k) % N);
      if (!valid_o && req_i[j] && !excl_i[j]) begin
        valid_o = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o = j;
      end
    end
  end
endmodule

// File: rtl/apb4_arbiter.sv
// apb4_arbiter: round-robin share of one downstream APB4 master port among NUM_REQ requesters
// Ports: clk_i/rst_i (sync active-high), req_if[NUM_REQ] upstream slave ports, master_if downstream port,
// gnt_o one-hot current grant. Optional APB4_ARB_TIMEOUT_EN adds an ACCESS-phase watchdog of TIMEOUT_CYCLES.
module apb4_arbiter import apb4_arb_pkg::*; #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic               clk_i,
  input  logic               rst_i,
  apb4_intf.slave            req_if [NUM_REQ],
  apb4_intf.master           master_if,
  output logic [NUM_REQ-1:0] gnt_o
);
  localparam int IW = idx_w(NUM_REQ);
  localparam int SW = strb_w(DATA_WIDTH);
  arb_state_e state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, req, pen, pwrite, win_gnt;
  logic [IW-1:0] idx_q, idx_d, ptr_q, ptr_d, nxt_ptr, win_idx;
  logic win_valid, done, rsp_ok, to, unused_ok;
  logic [ADDR_WIDTH-1:0] paddr [NUM_REQ];
  logic [DATA_WIDTH-1:0] pwdata [NUM_REQ];
  logic [SW-1:0] pstrb [NUM_REQ];
  logic [2:0] pprot [NUM_REQ];
  logic [ADDR_WIDTH-1:0] m_paddr;
  logic [DATA_WIDTH-1:0] m_pwdata;
  logic [SW-1:0] m_pstrb;
  logic [2:0] m_pprot;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign req[i] = req_if[i].PSEL;
    assign pen[i] = req_if[i].PENABLE;
    assign pwrite[i] = req_if[i].PWRITE;
    assign paddr[i] = req_if[i].PADDR;
    assign pwdata[i] = req_if[i].PWDATA;
    assign pstrb[i] = req_if[i].PSTRB;
    assign pprot[i] = req_if[i].PPROT;
    assign req_if[i].PREADY = grant_q[i] && done;
    assign req_if[i].PRDATA = (grant_q[i] && rsp_ok) ? master_if.PRDATA : '0;
    assign req_if[i].PSLVERR = grant_q[i] && (rsp_ok ? master_if.PSLVERR : to);
  end
  assign rsp_ok = state_q == ACCESS && master_if.PREADY;
  assign done = rsp_ok || to;
  assign nxt_ptr = (int'(idx_q) == NUM_REQ - 1) ? '0 : idx_q + 1'b1;
`ifdef APB4_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  // A genuine PREADY at the limit wins, so the watchdog only fires while the slave is still stalling.
  assign to = state_q == ACCESS && !master_if.PREADY && cnt_q == CW'(TIMEOUT_CYCLES);
  assign cnt_d = (state_q == SETUP) ? '0 :
                 (state_q == ACCESS && !master_if.PREADY && !to) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk_i) cnt_q <= rst_i ? '0 : cnt_d;
  assign unused_ok = ^pen;
`else
  assign to = 1'b0;
  assign unused_ok = ^{pen, TIMEOUT_CYCLES};
`endif
  // On completion the pointer advances past the grantee and the grantee sits out this one arbitration.
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_i  (req),
    .ptr_i  (done ? nxt_ptr : ptr_q),
    .excl_i (done ? grant_q : '0),
    .gnt_o  (win_gnt),
    .idx_o  (win_idx),
    .valid_o(win_valid)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q <= '0;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q <= idx_d;
      ptr_q <= ptr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d = idx_q;
    ptr_d = ptr_q;
    if (state_q == SETUP) state_d = ACCESS;
    else if (state_q == IDLE || done) begin
      ptr_d = done ? nxt_ptr : ptr_q;
      state_d = win_valid ? SETUP : IDLE;
      grant_d = win_valid ? win_gnt : '0;
      idx_d = win_valid ? win_idx : idx_q;
    end
  end
  // Grant-gated OR mux: zero in IDLE, and stable while grant_q holds.
  always_comb begin
    m_paddr = '0;
    m_pwdata = '0;
    m_pstrb = '0;
    m_pprot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      m_paddr = m_paddr | (grant_q[k] ? paddr[k] : '0);
      m_pwdata = m_pwdata | (grant_q[k] ? pwdata[k] : '0);
      m_pstrb = m_pstrb | (grant_q[k] ? pstrb[k] : '0);
      m_pprot = m_pprot | (grant_q[k] ? pprot[k] : '0);
    end
  end
  assign master_if.PSEL = state_q != IDLE;
  assign master_if.PENABLE = state_q == ACCESS;
  assign master_if.PWRITE = |(pwrite & grant_q);
  assign master_if.PADDR = m_paddr;
  assign master_if.PWDATA = m_pwdata;
  assign master_if.PSTRB = m_pstrb;
  assign master_if.PPROT = m_pprot;
  assign gnt_o = grant_q;
endmodule

// File: tb/tb_apb4_arbiter.sv
// tb_apb4_arbiter: directed self-checking bench for apb4_arbiter with two requesters
module tb_apb4_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] gnt;
  int errs = 0;
  int checks = 0;
  int stalled;
  apb4_intf rq [2] ();
  apb4_intf mst ();
  apb4_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst), .req_if(rq), .master_if(mst), .gnt_o(gnt)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic bus(input string tag, input logic s, input logic e, input logic [1:0] g);
    chk({tag, ".psel"}, 64'(mst.PSEL), 64'(s));
    chk({tag, ".penable"}, 64'(mst.PENABLE), 64'(e));
    chk({tag, ".gnt"}, 64'(gnt), 64'(g));
  endtask
  task automatic req(input int i, input logic sel, input logic [31:0] a, input logic wr, input logic [31:0] d);
    if (i == 0) begin
      rq[0].PSEL = sel; rq[0].PENABLE = 1'b0; rq[0].PADDR = a; rq[0].PWRITE = wr;
      rq[0].PWDATA = d; rq[0].PSTRB = 4'hf; rq[0].PPROT = 3'b001;
    end else begin
      rq[1].PSEL = sel; rq[1].PENABLE = 1'b0; rq[1].PADDR = a; rq[1].PWRITE = wr;
      rq[1].PWDATA = d; rq[1].PSTRB = 4'hc; rq[1].PPROT = 3'b010;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1;
    req(0, 0, 0, 0, 0);
    req(1, 0, 0, 0, 0);
    mst.PREADY = 1'b1; mst.PRDATA = '0; mst.PSLVERR = 1'b0;
    tick(); tick();
    bus("reset", 0, 0, 2'b00);
    chk("reset.rdy0", 64'(rq[0].PREADY), 0);
    chk("reset.rdy1", 64'(rq[1].PREADY), 0);
    chk("reset.err0", 64'(rq[0].PSLVERR), 0);
    chk("reset.rdata1", 64'(rq[1].PRDATA), 0);
    rst = 1'b0;
    // single write from requester 1, zero-wait slave
    tick(); req(1, 1, 32'h1000_0004, 1, 32'hDEAD_BEEF); settle();
    bus("t1c0", 0, 0, 2'b00);
    chk("t1c0.paddr", 64'(mst.PADDR), 0);
    tick(); settle();
    bus("t1c1", 1, 0, 2'b10);
    chk("t1c1.paddr", 64'(mst.PADDR), 64'h1000_0004);
    chk("t1c1.pwdata", 64'(mst.PWDATA), 64'hDEAD_BEEF);
    chk("t1c1.pwrite", 64'(mst.PWRITE), 1);
    chk("t1c1.pstrb", 64'(mst.PSTRB), 64'hc);
    chk("t1c1.pprot", 64'(mst.PPROT), 2);
    tick(); settle();
    bus("t1c2", 1, 1, 2'b10);
    chk("t1c2.rdy1", 64'(rq[1].PREADY), 1);
    chk("t1c2.rdy0", 64'(rq[0].PREADY), 0);
    tick(); req(1, 0, 0, 0, 0); settle();
    bus("t1c3", 0, 0, 2'b00);
    // collision after reset pointer: 0 then 1 back-to-back
    tick(); req(0, 1, 32'h100, 1, 32'h11); req(1, 1, 32'h200, 0, 0); settle();
    bus("t2c0", 0, 0, 2'b00);
    tick(); settle();
    bus("t2c1", 1, 0, 2'b01);
    chk("t2c1.paddr", 64'(mst.PADDR), 64'h100);
    tick(); settle();
    bus("t2c2", 1, 1, 2'b01);
    chk("t2c2.rdy0", 64'(rq[0].PREADY), 1);
    chk("t2c2.rdy1", 64'(rq[1].PREADY), 0);
    tick(); req(0, 0, 0, 0, 0); settle();
    bus("t2c3", 1, 0, 2'b10);
    chk("t2c3.paddr", 64'(mst.PADDR), 64'h200);
    chk("t2c3.pwrite", 64'(mst.PWRITE), 0);
    tick(); settle();
    bus("t2c4", 1, 1, 2'b10);
    chk("t2c4.rdy1", 64'(rq[1].PREADY), 1);
    chk("t2c4.rdy0", 64'(rq[0].PREADY), 0);
    tick(); req(1, 0, 0, 0, 0); settle();
    bus("t2c5", 0, 0, 2'b00);
    // read with 3 wait states; requester 1 arrives mid-transfer and must wait
    tick(); req(0, 1, 32'h2000_0008, 0, 0); mst.PREADY = 1'b0; settle();
    tick(); req(1, 1, 32'h300, 1, 32'h33); settle();
    bus("t3setup", 1, 0, 2'b01);
    for (int k = 0; k < 3; k++) begin
      tick(); settle();
      bus("t3wait", 1, 1, 2'b01);
      chk("t3wait.paddr", 64'(mst.PADDR), 64'h2000_0008);
      chk("t3wait.rdy0", 64'(rq[0].PREADY), 0);
      chk("t3wait.rdy1", 64'(rq[1].PREADY), 0);
    end
    tick(); mst.PREADY = 1'b1; mst.PRDATA = 32'h1234_5678; settle();
    bus("t3done", 1, 1, 2'b01);
    chk("t3done.paddr", 64'(mst.PADDR), 64'h2000_0008);
    chk("t3done.rdy0", 64'(rq[0].PREADY), 1);
    chk("t3done.rdata0", 64'(rq[0].PRDATA), 64'h1234_5678);
    chk("t3done.rdy1", 64'(rq[1].PREADY), 0);
    chk("t3done.rdata1", 64'(rq[1].PRDATA), 0);
    // error response to requester 1 only
    tick(); req(0, 0, 0, 0, 0); mst.PRDATA = '0; mst.PSLVERR = 1'b1; settle();
    bus("t4setup", 1, 0, 2'b10);
    chk("t4setup.paddr", 64'(mst.PADDR), 64'h300);
    chk("t4setup.err1", 64'(rq[1].PSLVERR), 0);
    tick(); settle();
    bus("t4acc", 1, 1, 2'b10);
    chk("t4acc.rdy1", 64'(rq[1].PREADY), 1);
    chk("t4acc.err1", 64'(rq[1].PSLVERR), 1);
    chk("t4acc.err0", 64'(rq[0].PSLVERR), 0);
    chk("t4acc.rdy0", 64'(rq[0].PREADY), 0);
    tick(); req(1, 0, 0, 0, 0); mst.PSLVERR = 1'b0; settle();
    bus("t4end", 0, 0, 2'b00);
    // lone requester 0 moves the pointer to 1
    tick(); req(0, 1, 32'h400, 1, 32'h44); settle();
    tick(); settle();
    bus("t5c1", 1, 0, 2'b01);
    tick(); settle();
    chk("t5c2.rdy0", 64'(rq[0].PREADY), 1);
    tick(); req(0, 0, 0, 0, 0); settle();
    bus("t5c3", 0, 0, 2'b00);
    // collision with pointer at 1: 1 first, then 0; 0 re-asserts and is excluded once
    tick(); req(0, 1, 32'h500, 1, 32'h55); req(1, 1, 32'h600, 1, 32'h66); settle();
    tick(); settle();
    bus("t6c1", 1, 0, 2'b10);
    chk("t6c1.paddr", 64'(mst.PADDR), 64'h600);
    tick(); settle();
    chk("t6c2.rdy1", 64'(rq[1].PREADY), 1);
    tick(); req(1, 0, 0, 0, 0); settle();
    bus("t6c3", 1, 0, 2'b01);
    chk("t6c3.paddr", 64'(mst.PADDR), 64'h500);
    tick(); settle();
    chk("t6c4.rdy0", 64'(rq[0].PREADY), 1);
    tick(); req(0, 1, 32'h700, 1, 32'h77); settle();
    bus("t6idle", 0, 0, 2'b00);
    tick(); settle();
    bus("t6c6", 1, 0, 2'b01);
    chk("t6c6.paddr", 64'(mst.PADDR), 64'h700);
    tick(); settle();
    chk("t6c7.rdy0", 64'(rq[0].PREADY), 1);
    tick(); req(0, 0, 0, 0, 0); settle();
    bus("t6c8", 0, 0, 2'b00);
    // slave never ready
    tick(); req(0, 1, 32'h800, 0, 0); mst.PREADY = 1'b0; mst.PRDATA = 32'hAAAA_5555; settle();
    tick(); settle();
    bus("t7setup", 1, 0, 2'b01);
`ifdef APB4_ARB_TIMEOUT_EN
    for (int k = 0; k < 4; k++) begin
      tick(); settle();
      bus("t7wait", 1, 1, 2'b01);
      chk("t7wait.rdy0", 64'(rq[0].PREADY), 0);
    end
    tick(); settle();
    chk("t7to.rdy0", 64'(rq[0].PREADY), 1);
    chk("t7to.err0", 64'(rq[0].PSLVERR), 1);
    chk("t7to.rdata0", 64'(rq[0].PRDATA), 0);
    chk("t7to.rdy1", 64'(rq[1].PREADY), 0);
    tick(); req(0, 0, 0, 0, 0); settle();
    bus("t7after", 0, 0, 2'b00);
    tick(); req(1, 1, 32'h900, 0, 0); settle();
    tick(); settle();
    tick(); settle();
    bus("t7acc1", 1, 1, 2'b10);
`else
    stalled = 0;
    for (int k = 0; k < 100; k++) begin
      tick(); settle();
      if (mst.PSEL && mst.PENABLE && gnt == 2'b01 && !rq[0].PREADY) stalled++;
    end
    chk("t7stall.cycles", 64'(stalled), 100);
`endif
    // reset in ACCESS
    rst = 1'b1;
    tick(); settle();
    bus("t8rst", 0, 0, 2'b00);
    chk("t8rst.rdy0", 64'(rq[0].PREADY), 0);
    chk("t8rst.rdy1", 64'(rq[1].PREADY), 0);
    rst = 1'b0; mst.PREADY = 1'b1; mst.PRDATA = '0;
    req(0, 1, 32'hA00, 1, 32'hAA); req(1, 1, 32'hB00, 1, 32'hBB); settle();
    chk("t8idle.rdy0", 64'(rq[0].PREADY), 0);
    chk("t8idle.err1", 64'(rq[1].PSLVERR), 0);
    tick(); settle();
    bus("t8ptr", 1, 0, 2'b01);
    chk("t8ptr.paddr", 64'(mst.PADDR), 64'hA00);
    tick(); settle();
    chk("t8acc.rdy0", 64'(rq[0].PREADY), 1);
    tick(); req(0, 0, 0, 0, 0); settle();
    bus("t8next", 1, 0, 2'b10);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
